// File: rtl/stream_arb_4_1.sv
// Round-robin 4:1 valid/ready stream arbiter with a single registered output stage.
// Optional STREAM_ARB_CNT_EN adds an 8-bit output handshake counter (xfer_cnt).
module stream_arb_4_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    output logic [3:0]   in_ready,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel
`ifdef STREAM_ARB_CNT_EN
    ,
    output logic [7:0]   xfer_cnt
`endif
);

    logic [1:0]   ptr_r;
    logic         out_valid_r;
    logic [W-1:0] out_data_r;
    logic [1:0]   out_sel_r;
    logic [1:0]   grant_idx_s;
    logic         any_valid_s;
    logic         load_s;
    logic [W-1:0] grant_data_s;

    // Round-robin search from ptr; scanning backwards leaves the nearest valid channel.
    always_comb begin
        grant_idx_s = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            grant_idx_s = in_valid[ptr_r + 2'(k)] ? (ptr_r + 2'(k)) : grant_idx_s;
        end
    end

    // Load when the output slot is empty or draining this cycle.
    always_comb begin
        any_valid_s = |in_valid;
        load_s      = (!out_valid_r || out_ready) && any_valid_s;
        if (load_s) begin
            in_ready = 4'b0001 << grant_idx_s;
        end else begin
            in_ready = 4'b0000;
        end
    end

    // Data select driven only by the granted index so other channels cannot leak X.
    always_comb begin
        case (grant_idx_s)
            2'd0:    grant_data_s = d0;
            2'd1:    grant_data_s = d1;
            2'd2:    grant_data_s = d2;
            2'd3:    grant_data_s = d3;
            default: grant_data_s = d0;
        endcase
    end

    // Output register stage and priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sel_r   <= 2'd0;
            ptr_r       <= 2'd0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= grant_data_s;
            out_sel_r   <= grant_idx_s;
            ptr_r       <= grant_idx_s + 2'd1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_sel   = out_sel_r;

`ifdef STREAM_ARB_CNT_EN
    logic [7:0] xfer_cnt_r;

    // Count completed output handshakes, wrapping naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_r <= 8'd0;
        end else if (out_valid_r && out_ready) begin
            xfer_cnt_r <= xfer_cnt_r + 8'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_stream_arb_4_1.sv
// Randomized + directed bench for stream_arb_4_1 against a transaction-level model.
module tb_stream_arb_4_1;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [W-1:0] d [4];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
`ifdef STREAM_ARB_CNT_EN
    logic [7:0]   xfer_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_valid;
    int m_data;
    int m_sel;
    int m_ptr;
    int m_cnt;

    always #5 clk = ~clk;

    stream_arb_4_1 #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
`ifdef STREAM_ARB_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // Starts and ends at a falling edge; checks all outputs before the rising edge.
    task automatic drive_cycle(input logic [3:0] v, input logic r);
        int  g;
        bit  load;
        logic [3:0] exp_ready;
        in_valid  = v;
        out_ready = r;
        #1;
        g = -1;
        for (int k = 0; k < 4; k++) begin
            if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
        load = (!m_valid || r) && (g >= 0);
        exp_ready = load ? 4'(1 << g) : 4'b0000;
        check("in_ready",  32'(in_ready),  32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  m_data);
        check("out_sel",   32'(out_sel),   m_sel);
`ifdef STREAM_ARB_CNT_EN
        check("xfer_cnt",  32'(xfer_cnt),  m_cnt);
`endif
        @(posedge clk);
        if (m_valid && r) m_cnt = (m_cnt + 1) % 256;
        if (load) begin
            m_valid = 1'b1;
            m_data  = int'(d[g]);
            m_sel   = g;
            m_ptr   = (g + 1) % 4;
        end else if (r) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset applied between edges; outputs must clear at once.
    task automatic apply_reset();
        in_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_sel",   32'(out_sel),   32'd0);
        check("rst_ready", 32'(in_ready),  32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        model_reset();
        @(negedge clk);

        // 1: reset then idle
        apply_reset();
        drive_cycle(4'b0000, 1'b0);
        drive_cycle(4'b0000, 1'b1);
        check("idle_valid", 32'(out_valid), 32'd0);

        // 2: single channel
        d[2] = 4'hC;
        drive_cycle(4'b0100, 1'b1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data",  32'(out_data),  32'hC);
        check("single_sel",   32'(out_sel),   32'd2);

        // 3: round-robin from ptr 0
        apply_reset();
        d[0] = 4'hA; d[1] = 4'hB; d[2] = 4'hC; d[3] = 4'hD;
        for (int k = 0; k < 5; k++) begin
            drive_cycle(4'b1111, 1'b1);
            check("rr_sel",  32'(out_sel),  32'(k % 4));
            check("rr_data", 32'(out_data), 32'(4'hA + 4'(k % 4)));
        end

        // 4: backpressure holding word B, then drain and refill without a bubble
        drive_cycle(4'b1111, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(4'b1111, 1'b0);
            check("stall_data", 32'(out_data), 32'hB);
            check("stall_sel",  32'(out_sel),  32'd1);
        end
        drive_cycle(4'b1111, 1'b1);
        check("refill_valid", 32'(out_valid), 32'd1);
        check("refill_data",  32'(out_data),  32'hC);
        check("refill_sel",   32'(out_sel),   32'd2);

        // 5: ptr=3 wraps to channel 0, then advances to channel 1
        apply_reset();
        drive_cycle(4'b0100, 1'b1);
        drive_cycle(4'b0011, 1'b1);
        check("wrap_sel", 32'(out_sel), 32'd0);
        drive_cycle(4'b0011, 1'b1);
        check("skip_sel", 32'(out_sel), 32'd1);

        // 6: reset during a stall, then first grant searches from channel 0
        drive_cycle(4'b1111, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        apply_reset();
`ifdef STREAM_ARB_CNT_EN
        check("cnt_after_rst", 32'(xfer_cnt), 32'd0);
`endif
        drive_cycle(4'b1010, 1'b1);
        check("post_rst_sel", 32'(out_sel), 32'd1);
        drive_cycle(4'b0000, 1'b1);
`ifdef STREAM_ARB_CNT_EN
        check("cnt_one", 32'(xfer_cnt), 32'd1);
`endif

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) d[i] = W'($urandom);
            if ($urandom_range(0, 99) == 0) apply_reset();
            else drive_cycle(4'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
